// File: rtl/btn_debounce.sv
// btn_debounce: two-channel pushbutton debouncer with registered level and rising-edge tick.
// Define BTN_DB_SYNC_EN to insert a two-flop synchronizer ahead of each channel FSM.
module btn_debounce #(
  parameter int CNT_W = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  output logic [1:0] db_level,
  output logic [1:0] db_tick
);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [1:0] s_in;
`ifdef BTN_DB_SYNC_EN
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  assign s_in = sync2_q;
`else
  assign s_in = btn_raw;
`endif
  for (genvar g = 0; g < 2; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d, tick_q, tick_d;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        state_q <= ZERO;
        cnt_q   <= '0;
        level_q <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        tick_q  <= tick_d;
      end
    // The window counts down to zero; the edge that sees zero with a stable input commits.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      tick_d  = 1'b0;
      case (state_q)
        ZERO:
          if (s_in[g]) begin
            state_d = WAIT1;
            cnt_d   = CNT_MAX;
          end
        WAIT1:
          if (!s_in[g]) state_d = ZERO;
          else if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
          else begin
            state_d = ONE;
            level_d = 1'b1;
            tick_d  = 1'b1;
          end
        ONE:
          if (!s_in[g]) begin
            state_d = WAIT0;
            cnt_d   = CNT_MAX;
          end
        WAIT0:
          if (s_in[g]) state_d = ONE;
          else if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
          else begin
            state_d = ZERO;
            level_d = 1'b0;
          end
        default: state_d = ZERO;
      endcase
    end
    assign db_level[g] = level_q;
    assign db_tick[g]  = tick_q;
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed table plus hand sequences for the debouncer at CNT_W=4.
module tb_btn_debounce;
  localparam int CNT_W = 4;
`ifdef BTN_DB_SYNC_EN
  localparam int LAT = (1 << CNT_W) + 2;
`else
  localparam int LAT = 1 << CNT_W;
`endif
  typedef struct {
    logic [1:0] btn;
    int         n;
    logic [1:0] lvl;
    logic [1:0] tick;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] db_level, db_tick;
  int passed = 0;
  int total = 0;
  vec_t tbl [10];

  btn_debounce #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .db_level(db_level), .db_tick(db_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] lvl, input logic [1:0] tick);
    total++;
    if (db_level === lvl && db_tick === tick) passed++;
    else $display("FAIL %s: level=%b tick=%b, required level=%b tick=%b",
                  name, db_level, db_tick, lvl, tick);
  endtask

  initial begin
    tbl[0] = '{2'b01, LAT, 2'b00, 2'b00};
    tbl[1] = '{2'b01, 1,   2'b01, 2'b01};
    tbl[2] = '{2'b01, 1,   2'b01, 2'b00};
    tbl[3] = '{2'b11, LAT, 2'b01, 2'b00};
    tbl[4] = '{2'b11, 1,   2'b11, 2'b10};
    tbl[5] = '{2'b11, 1,   2'b11, 2'b00};
    tbl[6] = '{2'b10, LAT, 2'b11, 2'b00};
    tbl[7] = '{2'b10, 1,   2'b10, 2'b00};
    tbl[8] = '{2'b00, LAT, 2'b10, 2'b00};
    tbl[9] = '{2'b00, 1,   2'b00, 2'b00};

    // Asynchronous reset with both buttons pressed, then the full window after release.
    #1 reset = 1'b0;
    btn_raw = 2'b11;
    #1 chk("reset_async", 2'b00, 2'b00);
    step(3);
    chk("reset_hold", 2'b00, 2'b00);
    reset = 1'b1;
    step(LAT);
    chk("post_reset_window", 2'b00, 2'b00);
    step(1);
    chk("post_reset_rise", 2'b11, 2'b11);
    step(1);
    chk("post_reset_tick_end", 2'b11, 2'b00);
    reset = 1'b0;
    #1 chk("reset_async_clear", 2'b00, 2'b00);
    step(1);
    btn_raw = 2'b00;
    reset = 1'b1;
    step(LAT + 2);
    chk("idle", 2'b00, 2'b00);

    for (int i = 0; i < 10; i++) begin
      btn_raw = tbl[i].btn;
      step(tbl[i].n);
      chk($sformatf("tbl[%0d]", i), tbl[i].lvl, tbl[i].tick);
    end

    // Short pulse on channel 1 never qualifies.
    btn_raw = 2'b10;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("short_pulse_hi", 2'b00, 2'b00);
    end
    btn_raw = 2'b00;
    for (int i = 0; i < LAT + 4; i++) begin
      step(1);
      chk("short_pulse_lo", 2'b00, 2'b00);
    end

    // Release glitch while held: level stays up, falls a full window after the final fall.
    btn_raw = 2'b01;
    step(LAT + 2);
    chk("glitch_held", 2'b01, 2'b00);
    btn_raw = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("glitch_low", 2'b01, 2'b00);
    end
    btn_raw = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("glitch_high", 2'b01, 2'b00);
    end
    btn_raw = 2'b00;
    for (int i = 0; i < LAT; i++) begin
      step(1);
      chk("final_fall_window", 2'b01, 2'b00);
    end
    step(1);
    chk("final_fall", 2'b00, 2'b00);
    step(3);

    // Reset mid-window aborts the count; a fresh window starts after release.
    btn_raw = 2'b11;
    step(11);
    chk("mid_window", 2'b00, 2'b00);
    reset = 1'b0;
    #1 chk("mid_window_reset", 2'b00, 2'b00);
    step(2);
    reset = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      step(1);
      chk("after_abort_window", 2'b00, 2'b00);
    end
    step(1);
    chk("after_abort_rise", 2'b11, 2'b11);
    step(1);
    chk("after_abort_tick_end", 2'b11, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter CNT_W, default 21, meaning debounce counter width; the stability window is 2^CNT_W clk cycles.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port btn_raw, input, 2 bits, raw asynchronous pushbutton levels, one per channel.
REQ-005 SHALL have port db_level, output, 2 bits, debounced registered button levels; these drive btn[1:0] of the pong graphics stage.
REQ-006 SHALL have port db_tick, output, 2 bits, one-cycle registered pulse on each debounced rising edge.

Function
REQ-007 SHALL process channels 0 and 1 independently, each with its own FSM, counter and synchronizer, with no cross-channel interaction.
REQ-008 SHALL give each channel's FSM the states ZERO, WAIT1, ONE and WAIT0; s_in is the channel's FSM input sample.
REQ-009 In ZERO, s_in=1 SHALL move the FSM to WAIT1 and load cnt with 2^CNT_W-1; s_in=0 SHALL hold ZERO.
REQ-010 In WAIT1, s_in=0 SHALL return the FSM to ZERO with no tick; if s_in=1 and cnt!=0, cnt SHALL decrement; if s_in=1 and cnt==0, the FSM SHALL go to ONE, set db_level=1 and assert db_tick=1 for exactly that cycle.
REQ-011 In ONE, s_in=0 SHALL move the FSM to WAIT0 and load cnt with 2^CNT_W-1; s_in=1 SHALL hold ONE.
REQ-012 In WAIT0, s_in=1 SHALL return the FSM to ONE; if s_in=0 and cnt!=0, cnt SHALL decrement; if s_in=0 and cnt==0, the FSM SHALL go to ZERO and clear db_level, with no tick.
REQ-013 SHALL give db_level a latency of exactly 2^CNT_W clk edges from the first edge that samples the new s_in level, provided s_in holds that level throughout.
REQ-014 Any glitch on s_in shorter than 2^CNT_W cycles SHALL leave db_level and db_tick unchanged, and SHALL restart the full window on the next qualifying edge.
REQ-015 SHALL never assert db_tick in any cycle where db_level is not transitioning 0->1; db_tick SHALL be high for at most one consecutive cycle per press.
REQ-016 SHALL keep cnt within CNT_W bits with no wrap below 0; cnt SHALL be loaded only on ZERO->WAIT1 or ONE->WAIT0.
REQ-017 Both db_level and db_tick SHALL be driven directly from flip-flops, with no combinational path from btn_raw.

Reset
REQ-018 reset low SHALL immediately (asynchronously) force each FSM to ZERO, cnt to 0, synchronizer flops to 0, db_level to 2'b00 and db_tick to 2'b00.
REQ-019 reset asserted mid-window (WAIT1/WAIT0) SHALL abort the window, with no tick after release.
REQ-020 After reset deasserts, the first rising clk edge SHALL resume normal operation from ZERO.

Configuration
REQ-021 With macro BTN_DB_SYNC_EN defined, s_in SHALL be btn_raw through a two-flop synchronizer per channel, adding 2 cycles of latency (raw change before edge e0 -> db_level change at edge e0+2^CNT_W+2).
REQ-022 With BTN_DB_SYNC_EN undefined, s_in SHALL be btn_raw sampled directly by the FSM (raw change before edge e0 -> db_level change at edge e0+2^CNT_W); all other behaviour SHALL be identical.

Verification (CNT_W=4, BTN_DB_SYNC_EN defined unless stated)
REQ-023 Reset low with btn_raw=2'b11 -> db_level=2'b00 and db_tick=2'b00 without waiting for a clk edge; both SHALL stay 0 until 18 edges after release.
REQ-024 btn_raw[0] 0->1 before edge e0 and held -> db_level[0]=1 and db_tick[0]=1 at e18; db_tick[0]=0 at e19; channel 1 stays 0.
REQ-025 btn_raw[1] pulsed high for 10 cycles, then low -> db_level[1] and db_tick[1] stay 0 throughout.
REQ-026 Button held with db_level=1, then btn_raw low 5 cycles, high 3, then low held -> db_level falls exactly 18 edges after the final fall, with no db_tick at any point.
REQ-027 Both channels rise on the same edge -> both db_tick bits pulse on the same cycle (edge e18); reset pulsed at e10 during WAIT1 instead -> no tick and db_level=0.
REQ-028 BTN_DB_SYNC_EN undefined, btn_raw[0] rises before e0 -> db_level[0]=1 and db_tick[0]=1 at e16.
